hop_input_gen: RTL and testbench

//  Upstream stage of the hop kernel (Core 5.1 Vol2 PartB 2.6.2). Per hop, latches mode, clocks and address, then produces
//  X,A,B,C,D,E,F,F',Y1,Y2 with one registered update. F/F' (16*CLK[27:7] mod 79 / mod N) use a bit-serial reducer.

---
 rtl/hop_input_gen.sv | 279 +++++++++++++++++++++++++++
 tb/tb_hop_input_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hop_input_gen.sv
// Hop-kernel input stage: latches the hop context on an accepted hop_tick and forms X..Y2 after a 25-cycle serial mod reduction.
// Optional build macro INTERLACE_SCAN_EN adds the scan_interlace input (X += 16 in PSCAN/ISCAN).
module hop_input_gen #(
  parameter int TRAIN_TICKS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hop_tick,
  input  logic [2:0]  mode,
  input  logic        page_hit,
  input  logic        role_slave,
  input  logic [27:0] addr,
  input  logic [27:0] clkn,
  input  logic [27:0] clke,
  input  logic        afh_en,
  input  logic [6:0]  afh_n,
`ifdef INTERLACE_SCAN_EN
  input  logic        scan_interlace,
`endif
  output logic        busy,
  output logic        hop_valid,
  output logic [4:0]  X,
  output logic [4:0]  A,
  output logic [3:0]  B,
  output logic [4:0]  C,
  output logic [8:0]  D,
  output logic [6:0]  E,
  output logic [6:0]  F,
  output logic [6:0]  Fprime,
  output logic        Y1,
  output logic [5:0]  Y2
);

  // state | meaning
  // IDLE  | waiting for hop_tick, hop context may be sampled
  // CALC  | 25 reducer steps over the sampled clock
  // DONE  | all kernel outputs load, hop_valid pulses next cycle
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [2:0] MD_PSCAN = 3'd0;
  localparam logic [2:0] MD_PAGE  = 3'd1;
  localparam logic [2:0] MD_MRESP = 3'd2;
  localparam logic [2:0] MD_SRESP = 3'd3;
  localparam logic [2:0] MD_ISCAN = 3'd4;
  localparam logic [2:0] MD_INQ   = 3'd5;
  localparam logic [2:0] MD_IRESP = 3'd6;
  localparam logic [2:0] MD_CONN  = 3'd7;

  localparam int TCW = (TRAIN_TICKS > 2) ? $clog2(TRAIN_TICKS) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TRAIN_TICKS - 1);

  state_t         state_q, state_d;
  logic [4:0]     step_q;
  logic           accept, load_out;

  logic [2:0]     mode_last;
  logic [27:0]    clke_f, clkn_f;
  logic [4:0]     n_cnt;
  logic [TCW-1:0] tc_q;
  logic           train_b_q;

  logic [2:0]     mode_s;
  logic [27:0]    addr_s, clk_s;
  logic           afh_en_s;
  logic [6:0]     afh_n_s;
  logic [4:0]     n_s, koff_s;
`ifdef INTERLACE_SCAN_EN
  logic           interlace_s;
`endif

  logic [6:0]     r79_q, rn_q;

  logic           mode_chg, page_entry, is_resp, is_page;
  logic [4:0]     n_base;
  logic [TCW-1:0] tc_base;
  logic           train_base;
  logic [27:0]    clke_fz, clkn_fz, clk_pick;
  logic [4:0]     bit_idx;
  logic           shift_bit;

  function automatic logic [6:0] red_step(input logic [6:0] r, input logic b, input logic [6:0] m);
    logic [7:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[6:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_out = 1'b0;
    busy     = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (hop_tick) begin
          accept  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: if (step_q == 5'd24) state_d = S_DONE;
      S_DONE: begin
        load_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Context clears (page_hit, mode change) take effect before the same-cycle tick is sampled.
  always_comb begin
    mode_chg   = (mode != mode_last);
    page_entry = mode_chg && ((mode == MD_PAGE) || (mode == MD_INQ));
    is_resp    = (mode == MD_MRESP) || (mode == MD_SRESP) || (mode == MD_IRESP);
    is_page    = (mode == MD_PAGE) || (mode == MD_INQ);
    n_base     = (page_hit || mode_chg) ? 5'd0 : n_cnt;
    tc_base    = page_entry ? '0 : tc_q;
    train_base = page_entry ? 1'b0 : train_b_q;
    clke_fz    = page_hit ? clke : clke_f;
    clkn_fz    = page_hit ? clkn : clkn_f;
    case (mode)
      MD_PAGE, MD_INQ: clk_pick = clke;
      MD_MRESP:        clk_pick = clke_fz;
      MD_SRESP:        clk_pick = clkn_fz;
      MD_CONN:         clk_pick = role_slave ? clke : clkn;
      default:         clk_pick = clkn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_last <= 3'd0;
      clke_f    <= 28'd0;
      clkn_f    <= 28'd0;
      n_cnt     <= 5'd0;
      tc_q      <= '0;
      train_b_q <= 1'b0;
      mode_s    <= 3'd0;
      addr_s    <= 28'd0;
      clk_s     <= 28'd0;
      afh_en_s  <= 1'b0;
      afh_n_s   <= 7'd0;
      n_s       <= 5'd0;
      koff_s    <= 5'd24;
`ifdef INTERLACE_SCAN_EN
      interlace_s <= 1'b0;
`endif
    end else begin
      mode_last <= mode;
      if (page_hit) begin
        clke_f <= clke;
        clkn_f <= clkn;
      end
      n_cnt     <= n_base;
      tc_q      <= tc_base;
      train_b_q <= train_base;
      if (accept) begin
        mode_s   <= mode;
        addr_s   <= addr;
        clk_s    <= clk_pick;
        afh_en_s <= afh_en;
        afh_n_s  <= afh_n;
        n_s      <= n_base;
        koff_s   <= train_base ? 5'd8 : 5'd24;
`ifdef INTERLACE_SCAN_EN
        interlace_s <= scan_interlace;
`endif
        if (is_resp) n_cnt <= n_base + 5'd1;
        if (is_page) begin
          if (tc_base == TC_LAST) begin
            tc_q      <= '0;
            train_b_q <= ~train_base;
          end else begin
            tc_q <= tc_base + TCW'(1);
          end
        end
      end
    end
  end

  // Steps 0..20 shift in CLK[27:7] MSB-first; steps 21..24 only double (the *16).
  assign bit_idx   = 5'd27 - step_q;
  assign shift_bit = (step_q < 5'd21) ? clk_s[bit_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 5'd0;
      r79_q  <= 7'd0;
      rn_q   <= 7'd0;
    end else if (accept) begin
      step_q <= 5'd0;
      r79_q  <= 7'd0;
      rn_q   <= 7'd0;
    end else if (state_q == S_CALC) begin
      step_q <= step_q + 5'd1;
      r79_q  <= red_step(r79_q, shift_bit, 7'd79);
      rn_q   <= red_step(rn_q, shift_bit, afh_n_s);
    end
  end

  logic       conn_s;
  logic [3:0] page_off;
  logic [4:0] page_x, x_d;
  logic       y1_d;

  always_comb begin
    conn_s   = (mode_s == MD_CONN);
    page_off = {clk_s[4:2], clk_s[0]} - clk_s[15:12];
    page_x   = clk_s[16:12] + koff_s + {1'b0, page_off};
    x_d      = 5'd0;
    y1_d     = 1'b0;
    case (mode_s)
      MD_PSCAN, MD_ISCAN: begin
`ifdef INTERLACE_SCAN_EN
        x_d = clk_s[16:12] + {interlace_s, 4'b0000};
`else
        x_d = clk_s[16:12];
`endif
      end
      MD_PAGE, MD_INQ: begin
        x_d  = page_x;
        y1_d = clk_s[1];
      end
      MD_MRESP: begin
        x_d  = page_x + n_s;
        y1_d = clk_s[1];
      end
      MD_SRESP: begin
        x_d  = clk_s[16:12] + n_s;
        y1_d = clk_s[1];
      end
      MD_IRESP: begin
        x_d  = clk_s[16:12] + n_s;
        y1_d = 1'b1;
      end
      default: begin
        x_d  = clk_s[6:2];
        y1_d = clk_s[1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hop_valid <= 1'b0;
      X         <= 5'd0;
      A         <= 5'd0;
      B         <= 4'd0;
      C         <= 5'd0;
      D         <= 9'd0;
      E         <= 7'd0;
      F         <= 7'd0;
      Fprime    <= 7'd0;
      Y1        <= 1'b0;
      Y2        <= 6'd0;
    end else begin
      hop_valid <= load_out;
      if (load_out) begin
        X      <= x_d;
        A      <= addr_s[27:23] ^ (conn_s ? clk_s[25:21] : 5'd0);
        B      <= addr_s[22:19];
        C      <= {addr_s[8], addr_s[6], addr_s[4], addr_s[2], addr_s[0]} ^
                  (conn_s ? clk_s[20:16] : 5'd0);
        D      <= addr_s[18:10] ^ (conn_s ? clk_s[15:7] : 9'd0);
        E      <= {addr_s[13], addr_s[11], addr_s[9], addr_s[7], addr_s[5], addr_s[3], addr_s[1]};
        F      <= conn_s ? r79_q : 7'd0;
        Fprime <= (conn_s && afh_en_s) ? rn_q : 7'd0;
        Y1     <= y1_d;
        Y2     <= {y1_d, 5'b00000};
      end
    end
  end

endmodule

// File: tb/tb_hop_input_gen.sv
// Bench for hop_input_gen: vector table plus hand sequences for train toggle, response counter, busy and abort.
module tb_hop_input_gen;
  localparam int TT = 4;

  logic        clk = 1'b0;
  logic        rst, hop_tick, page_hit, role_slave, afh_en;
  logic [2:0]  mode;
  logic [27:0] addr, clkn, clke;
  logic [6:0]  afh_n;
  logic        busy, hop_valid;
  logic [4:0]  X, A, C;
  logic [3:0]  B;
  logic [8:0]  D;
  logic [6:0]  E, F, Fprime;
  logic        Y1;
  logic [5:0]  Y2;

  hop_input_gen #(.TRAIN_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .hop_tick(hop_tick), .mode(mode), .page_hit(page_hit),
    .role_slave(role_slave), .addr(addr), .clkn(clkn), .clke(clke), .afh_en(afh_en),
    .afh_n(afh_n), .busy(busy), .hop_valid(hop_valid), .X(X), .A(A), .B(B), .C(C),
    .D(D), .E(E), .F(F), .Fprime(Fprime), .Y1(Y1), .Y2(Y2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, a, b, c, d, e, f, fp, y1, y2;
  } exp_t;

  typedef struct {
    logic [2:0]  md;
    logic        role;
    logic [27:0] ad, cn, ce;
    logic        en;
    logic [6:0]  n;
    int          x, f, fp, y1;
  } vec_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic [2:0] md, input logic [27:0] ad, input logic [27:0] ck,
                                  input int x, input int f, input int fp, input int y1);
    exp_t r;
    logic [4:0] cc;
    logic [6:0] ee;
    logic [4:0] aa;
    logic [8:0] dd;
    for (int i = 0; i < 5; i++) cc[i] = ad[2*i];
    for (int i = 0; i < 7; i++) ee[i] = ad[2*i+1];
    aa = ad[27:23];
    dd = ad[18:10];
    if (md == 3'd7) begin
      aa = aa ^ ck[25:21];
      cc = cc ^ ck[20:16];
      dd = dd ^ ck[15:7];
    end
    r.x = x; r.a = aa; r.b = ad[22:19]; r.c = cc; r.d = dd; r.e = ee;
    r.f = f; r.fp = fp; r.y1 = y1; r.y2 = y1 * 32;
    return r;
  endfunction

  // retick > 0: a second hop_tick lands that many cycles after the first and must be ignored.
  task automatic run_hop(input exp_t ex, input logic ph, input int retick);
    int cyc;
    int extra;
    exp_t w;
    sb.push_back(ex);
    @(posedge clk); #1 hop_tick = 1'b1; page_hit = ph;
    @(posedge clk); #1 hop_tick = 1'b0; page_hit = 1'b0;
    cyc = 1;
    while (!hop_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      hop_tick = (retick > 0 && cyc == retick);
    end
    hop_tick = 1'b0;
    check("hop_valid_seen", hop_valid, 1);
    check("latency", cyc, 27);
    w = sb.pop_front();
    check("X", X, w.x);   check("A", A, w.a);   check("B", B, w.b);
    check("C", C, w.c);   check("D", D, w.d);   check("E", E, w.e);
    check("F", F, w.f);   check("Fprime", Fprime, w.fp);
    check("Y1", Y1, w.y1); check("Y2", Y2, w.y2);
    if (retick > 0) begin
      extra = 0;
      repeat (35) begin
        @(posedge clk); #1;
        if (hop_valid) extra++;
      end
      check("extra_hop_valid", extra, 0);
    end
  endtask

  task automatic drive(input vec_t v);
    mode = v.md; role_slave = v.role; addr = v.ad; clkn = v.cn; clke = v.ce;
    afh_en = v.en; afh_n = v.n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    exp_t ex;
    int hv;

    rst = 1'b1; hop_tick = 1'b0; page_hit = 1'b0; role_slave = 1'b0; afh_en = 1'b0;
    mode = 3'd0; addr = '0; clkn = '0; clke = '0; afh_n = 7'd79;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0); check("rst_hop_valid", hop_valid, 0);
    check("rst_X", X, 0); check("rst_A", A, 0); check("rst_D", D, 0);
    check("rst_F", F, 0); check("rst_Fprime", Fprime, 0); check("rst_Y2", Y2, 0);

    //            md    role  addr           clkn           clke           en    n      x   f   fp  y1
    tbl[0] = '{3'd7, 1'b1, 28'h0000000, 28'h1234567, 28'h0000280, 1'b1, 7'd20, 0,  1,  0,  0};
    tbl[1] = '{3'd7, 1'b0, 28'hA5C3E97, 28'h000009E, 28'hFFFFFFF, 1'b1, 7'd79, 7,  16, 16, 1};
    tbl[2] = '{3'd7, 1'b0, 28'h0000000, 28'hFFFFFFF, 28'h0000000, 1'b0, 7'd79, 31, 35, 0,  1};
    tbl[3] = '{3'd7, 1'b1, 28'h5A5A5A5, 28'h0000000, 28'h00001FC, 1'b1, 7'd20, 31, 48, 8,  0};
    tbl[4] = '{3'd0, 1'b0, 28'hFFFFFFF, 28'h0015002, 28'h0000000, 1'b1, 7'd40, 21, 0,  0,  0};
    tbl[5] = '{3'd4, 1'b1, 28'h1234567, 28'h0FE0FFF, 28'hFFFFFFF, 1'b1, 7'd40, 0,  0,  0,  0};
    tbl[6] = '{3'd1, 1'b0, 28'h0F0F0F0, 28'hFFFFFFF, 28'h0003003, 1'b1, 7'd79, 9,  0,  0,  1};

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 drive(tbl[i]);
      ex = mk_exp(tbl[i].md, tbl[i].ad, tbl[i].role ? tbl[i].ce : tbl[i].cn,
                  tbl[i].x, tbl[i].f, tbl[i].fp, tbl[i].y1);
      run_hop(ex, 1'b0, 0);
    end

    // PAGE continues: ticks 2..4 on train A, ticks 5..8 on train B, tick 8 flips back to A.
    v = tbl[6];
    for (int k = 2; k <= 8; k++) begin
      ex = mk_exp(v.md, v.ad, v.ce, (k <= TT) ? 9 : 25, 0, 0, 1);
      run_hop(ex, 1'b0, 0);
    end

    // MRESP on clke frozen by page_hit; live clke changes must not matter.
    @(posedge clk); #1 page_hit = 1'b1;
    @(posedge clk); #1 page_hit = 1'b0; mode = 3'd2;
    for (int k = 0; k < 3; k++) begin
      clke = 28'h1F1F1F * (k + 1);
      ex = mk_exp(3'd2, v.ad, 28'd0, 9 + k, 0, 0, 1);
      run_hop(ex, 1'b0, 0);
    end

    // SRESP with page_hit coincident with the tick: freeze happens first.
    mode = 3'd3; clkn = 28'h0005002;
    ex = mk_exp(3'd3, v.ad, 28'd0, 5, 0, 0, 1);
    run_hop(ex, 1'b1, 0);
    clkn = 28'h001F000;
    ex = mk_exp(3'd3, v.ad, 28'd0, 6, 0, 0, 1);
    run_hop(ex, 1'b0, 0);

    // IRESP: N wraps X from 31 to 0.
    mode = 3'd6; clkn = 28'h001F000;
    ex = mk_exp(3'd6, v.ad, 28'd0, 31, 0, 0, 1);
    run_hop(ex, 1'b0, 0);
    ex = mk_exp(3'd6, v.ad, 28'd0, 0, 0, 0, 1);
    run_hop(ex, 1'b0, 0);

    // Tick while busy is ignored and does not advance N.
    clkn = 28'h000A000;
    ex = mk_exp(3'd6, v.ad, 28'd0, 12, 0, 0, 1);
    run_hop(ex, 1'b0, 5);
    ex = mk_exp(3'd6, v.ad, 28'd0, 13, 0, 0, 1);
    run_hop(ex, 1'b0, 0);

    // Reset in the middle of CALC aborts the hop.
    @(posedge clk); #1 hop_tick = 1'b1;
    @(posedge clk); #1 hop_tick = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (hop_valid) hv++;
    end
    check("abort_hop_valid", hv, 0);
    check("abort_busy", busy, 0);
    check("abort_X", X, 0);
    check("abort_A", A, 0);
    check("abort_Y1", Y1, 0);

    @(posedge clk); #1 drive(tbl[4]);
    ex = mk_exp(3'd0, tbl[4].ad, 28'd0, 21, 0, 0, 0);
    run_hop(ex, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
